generic_sequential_divider: RTL

Unsigned N-bit restoring divider that computes quotient and remainder by repeated shift-and-subtract, one quotient bit per clock. It is the arithmetic inverse companion to the team's combinational adder/subtractor and multiplier blocks. It sits in datapaths that need division without a wide combinational array, with a start/busy/done handshake to the controlling FSM.

---
 rtl/generic_sequential_divider.sv | 123 ++++++++++++
 1 files changed

// File: rtl/generic_sequential_divider.sv
// Unsigned N-bit restoring divider. Produces one quotient bit per clock and
// uses a start/busy/done handshake. Divide-by-zero finishes in a single cycle.
module generic_sequential_divider #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         busy,
   output logic         done,
   output logic         divByZero
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(N);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  d_q, d_d;      // dividend bits shift out of the MSB, quotient bits shift in at the LSB
   logic [N-1:0]  v_q, v_d;
   logic [N:0]    r_q, r_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  quo_q, quo_d;
   logic [N-1:0]  rem_q, rem_d;
   logic          dbz_q, dbz_d;

   logic [N+1:0]  r_wide;
   logic [N+1:0]  trial;
   logic          no_borrow;
   logic [N:0]    r_step;
   logic [N-1:0]  d_step;

   // The subtraction carries one extra bit so its sign bit is the borrow flag.
   always_comb begin
      r_wide    = {r_q, d_q[N-1]};
      trial     = r_wide - {2'b00, v_q};
      no_borrow = ~trial[N+1];
      r_step    = no_borrow ? trial[N:0] : r_wide[N:0];
      d_step    = {d_q[N-2:0], no_borrow};
   end

   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      v_d     = v_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               if (divisor == '0) begin
                  state_d = S_DONE;
                  quo_d   = '1;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = S_RUN;
                  d_d     = dividend;
                  v_d     = divisor;
                  r_d     = '0;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         S_RUN: begin
            d_d   = d_step;
            r_d   = r_step;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = S_DONE;
               quo_d   = d_step;
               rem_d   = r_step[N-1:0];
               dbz_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         d_q     <= '0;
         v_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         v_q     <= v_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign divByZero = dbz_q;
   assign busy      = (state_q == S_RUN);
   assign done      = (state_q == S_DONE);

endmodule
